// File: rtl/ifetch_pkg.sv
// Shared constants for the AXI4-Lite instruction fetch unit.
package ifetch_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_RESP  = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

endpackage

// File: rtl/ifetch_axi.sv
// AXI4-Lite read master that owns the PC, fetches one instruction at a time
// and presents it to decode; handles execute redirects and sticky faults.
module ifetch_axi
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned AXI_AWIDTH = 32,
    parameter int unsigned AXI_DWIDTH = 32,
    parameter int unsigned WORD_ADDR  = 0
) (
    input  logic                  AXI_ACLK,
    input  logic                  AXI_ARESET,
    output logic [AXI_AWIDTH-1:0] AXI_ARADDR,
    output logic                  AXI_ARVALID,
    input  logic                  AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0] AXI_RDATA,
    input  logic [1:0]            AXI_RRESP,
    input  logic                  AXI_RVALID,
    output logic                  AXI_RREADY,
    input  logic                  REDIR_VALID,
    input  logic [31:0]           REDIR_PC,
    output logic                  INSTR_VALID,
    input  logic                  INSTR_READY,
    output logic [31:0]           INSTR_DATA,
    output logic [31:0]           INSTR_PC,
    output logic                  FETCH_FAULT
);

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redir_pc;
    logic        r_flush;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_ivalid;
    logic [31:0] r_idata;
    logic [31:0] r_ipc;
    logic        r_fault;

    logic [31:0] w_start_pc;
    logic        w_start_ok;
    logic [2:0]  w_start_state;
    logic        w_rsp_done;
    logic        w_discard;

    // ARADDR is a pure slice of the PC register, so it stays registered.
    assign AXI_ARADDR  = (WORD_ADDR != 0) ? AXI_AWIDTH'(r_pc >> 2) : AXI_AWIDTH'(r_pc);
    assign AXI_ARVALID = r_arvalid;
    assign AXI_RREADY  = r_rready;
    assign INSTR_VALID = r_ivalid;
    assign INSTR_DATA  = r_idata;
    assign INSTR_PC    = r_ipc;
    assign FETCH_FAULT = r_fault;

    // PC used for the next request: a live redirect wins, otherwise a pending
    // one while a transaction is draining, otherwise the current PC.
    always_comb begin
        w_start_pc = r_pc;
        if (REDIR_VALID) begin
            w_start_pc = REDIR_PC;
        end else if (r_state == S_REQ || r_state == S_RESP) begin
            w_start_pc = r_redir_pc;
        end
        w_start_ok    = (w_start_pc[1:0] == 2'b00);
        w_start_state = w_start_ok ? S_REQ : S_FAULT;
        w_rsp_done    = ((r_state == S_REQ) && AXI_ARREADY && AXI_RVALID) ||
                        ((r_state == S_RESP) && AXI_RVALID);
        w_discard     = r_flush || REDIR_VALID;
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_redir_pc <= '0;
            r_flush    <= 1'b0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_ivalid   <= 1'b0;
            r_idata    <= NOP_INSTR;
            r_ipc      <= RESET_PC;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pc      <= w_start_pc;
                    r_state   <= w_start_state;
                    r_arvalid <= w_start_ok;
                    r_rready  <= w_start_ok;
                    r_fault   <= ~w_start_ok;
                end

                S_REQ, S_RESP: begin
                    if (REDIR_VALID) begin
                        r_flush    <= 1'b1;
                        r_redir_pc <= REDIR_PC;
                    end
                    if (r_state == S_REQ && AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        if (!AXI_RVALID) begin
                            r_state <= S_RESP;
                        end
                    end
                    // Later assignments here override the flush/arvalid updates above.
                    if (w_rsp_done) begin
                        r_rready <= 1'b0;
                        r_flush  <= 1'b0;
                        if (w_discard) begin
                            r_pc      <= w_start_pc;
                            r_state   <= w_start_state;
                            r_arvalid <= w_start_ok;
                            r_rready  <= w_start_ok;
                            r_fault   <= ~w_start_ok;
                        end else if (AXI_RRESP != RESP_OKAY) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_idata <= AXI_RDATA[31:0];
                            r_ipc   <= r_pc;
                            r_pc    <= r_pc + 32'd4;
                            r_state <= S_OUT;
                        end
                    end
                end

                S_OUT: begin
                    if (REDIR_VALID || (r_ivalid && INSTR_READY)) begin
                        r_ivalid  <= 1'b0;
                        r_pc      <= w_start_pc;
                        r_state   <= w_start_state;
                        r_arvalid <= w_start_ok;
                        r_rready  <= w_start_ok;
                        r_fault   <= ~w_start_ok;
                    end else begin
                        r_ivalid <= 1'b1;
                    end
                end

                S_FAULT: begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_ivalid  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_axi.sv
// Directed bench for ifetch_axi: table of sequential fetches plus hand-written
// redirect, fault and word-address sequences against a small AXI slave model.
module tb_ifetch_axi;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] araddr;
    logic        arvalid, rready, ivalid, fault;
    logic        arready = 1'b0, rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        redir_valid = 1'b0, iready = 1'b0;
    logic [31:0] redir_pc = '0;
    logic [31:0] idata, ipc;

    logic [31:0] w_araddr, w_idata, w_ipc;
    logic        w_arvalid, w_rready, w_ivalid, w_fault;

    ifetch_axi #(.RESET_PC(32'h0000_0100), .AXI_AWIDTH(32), .AXI_DWIDTH(32), .WORD_ADDR(0)) dut (
        .AXI_ACLK(clk), .AXI_ARESET(rst),
        .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready),
        .REDIR_VALID(redir_valid), .REDIR_PC(redir_pc),
        .INSTR_VALID(ivalid), .INSTR_READY(iready), .INSTR_DATA(idata), .INSTR_PC(ipc),
        .FETCH_FAULT(fault)
    );

    ifetch_axi #(.RESET_PC(32'h0000_0010), .AXI_AWIDTH(32), .AXI_DWIDTH(32), .WORD_ADDR(1)) dut_w (
        .AXI_ACLK(clk), .AXI_ARESET(rst),
        .AXI_ARADDR(w_araddr), .AXI_ARVALID(w_arvalid), .AXI_ARREADY(1'b0),
        .AXI_RDATA(32'h0), .AXI_RRESP(2'b00), .AXI_RVALID(1'b0), .AXI_RREADY(w_rready),
        .REDIR_VALID(1'b0), .REDIR_PC(32'h0),
        .INSTR_VALID(w_ivalid), .INSTR_READY(1'b0), .INSTR_DATA(w_idata), .INSTR_PC(w_ipc),
        .FETCH_FAULT(w_fault)
    );

    // Slave model state; driven on the falling edge for the following rising edge.
    int unsigned s_lat = 0, s_cnt = 0, ar_count = 0;
    logic        s_busy = 1'b0, s_arhs = 1'b0, s_rhs = 1'b0, s_ar_en = 1'b1;
    logic [1:0]  s_resp = 2'b00;
    logic [31:0] s_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0050_0093 : {a[19:0], 12'h013};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            s_busy = 1'b0; s_arhs = 1'b0; s_rhs = 1'b0;
            arready = 1'b0; rvalid = 1'b0;
        end else begin
            if (s_rhs) s_busy = 1'b0;
            if (s_arhs && s_lat != 0) begin
                s_busy = 1'b1; s_cnt = s_lat;
            end
            if (s_busy) begin
                arready = 1'b0;
                if (s_cnt > 1) begin
                    s_cnt--; rvalid = 1'b0;
                end else begin
                    rvalid = 1'b1; rdata = mem_word(s_addr); rresp = s_resp;
                end
            end else begin
                arready = arvalid && s_ar_en;
                rvalid  = (s_lat == 0) && arvalid && s_ar_en;
                rdata   = mem_word(araddr);
                rresp   = s_resp;
            end
            s_arhs = arvalid && arready;
            if (s_arhs) begin
                s_addr = araddr;
                ar_count++;
            end
            s_rhs = rready && rvalid;
        end
    end

    int unsigned n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic sel_sig(input int unsigned sel);
        case (sel)
            0:       return ivalid;
            1:       return arvalid;
            default: return fault;
        endcase
    endfunction

    task automatic wait_until(input int unsigned sel, input string nm);
        int unsigned n = 0;
        while (!sel_sig(sel) && n < 30) begin
            step();
            n++;
        end
        chk(nm, 32'(sel_sig(sel)), 32'd1);
    endtask

    typedef struct {
        int unsigned lat;
        int unsigned stall;
        logic [31:0] pc;
        logic [31:0] data;
        int unsigned lat_exp;
    } vec_t;

    vec_t        vecs[5];
    int unsigned t, ar0;

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{lat: 0, stall: 0, pc: 32'h100, data: 32'h0050_0093, lat_exp: 2};
        vecs[1] = '{lat: 0, stall: 5, pc: 32'h104, data: 32'h0010_4013, lat_exp: 2};
        vecs[2] = '{lat: 1, stall: 0, pc: 32'h108, data: 32'h0010_8013, lat_exp: 3};
        vecs[3] = '{lat: 3, stall: 2, pc: 32'h10C, data: 32'h0010_C013, lat_exp: 5};
        vecs[4] = '{lat: 0, stall: 1, pc: 32'h110, data: 32'h0011_0013, lat_exp: 2};

        step();
        step();
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_ivalid", 32'(ivalid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_idata", idata, NOP_INSTR);
        chk("rst_ipc", ipc, 32'h100);
        chk("rst_araddr", araddr, 32'h100);
        chk("rst_word_araddr", w_araddr, 32'h4);
        s_lat = vecs[0].lat;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            wait_until(1, "arvalid_rise");
            chk("fetch_araddr", araddr, vecs[i].pc);
            chk("fetch_rready", 32'(rready), 32'd1);
            t = 0;
            while (!ivalid && t < 20) begin
                step();
                t++;
            end
            chk("fetch_latency", t, vecs[i].lat_exp);
            chk("fetch_ipc", ipc, vecs[i].pc);
            chk("fetch_idata", idata, vecs[i].data);
            ar0 = ar_count;
            for (int k = 0; k < int'(vecs[i].stall); k++) begin
                step();
                chk("stall_valid", 32'(ivalid), 32'd1);
                chk("stall_data", idata, vecs[i].data);
                chk("stall_pc", ipc, vecs[i].pc);
                chk("stall_arvalid", 32'(arvalid), 32'd0);
            end
            chk("stall_no_fetch", ar_count, ar0);
            iready = 1'b1;
            s_lat = (i < 4) ? vecs[i + 1].lat : 3;
            step();
            iready = 1'b0;
            chk("accept_ivalid_drop", 32'(ivalid), 32'd0);
        end
        chk("word_arvalid", 32'(w_arvalid), 32'd1);
        chk("word_araddr", w_araddr, 32'h4);

        // Redirect while waiting for a delayed response
        step();
        chk("resp_wait_arvalid", 32'(arvalid), 32'd0);
        redir_valid = 1'b1; redir_pc = 32'h200; s_lat = 0;
        step();
        redir_valid = 1'b0;
        wait_until(1, "redir_resp_arvalid");
        chk("redir_resp_araddr", araddr, 32'h200);
        chk("redir_resp_ivalid", 32'(ivalid), 32'd0);
        chk("redir_resp_ipc", ipc, 32'h110);
        wait_until(0, "redir_resp_fetch");
        chk("redir_resp_fetch_pc", ipc, 32'h200);
        chk("redir_resp_fetch_data", idata, 32'h0020_0013);

        // Redirect coincident with the decode handshake
        iready = 1'b1; redir_valid = 1'b1; redir_pc = 32'h300;
        step();
        iready = 1'b0; redir_valid = 1'b0;
        chk("redir_hs_ivalid", 32'(ivalid), 32'd0);
        chk("redir_hs_araddr", araddr, 32'h300);
        wait_until(0, "redir_hs_fetch");
        chk("redir_hs_fetch_pc", ipc, 32'h300);
        chk("redir_hs_fetch_data", idata, 32'h0030_0013);

        // Redirect in S_OUT, then back-to-back redirects while ARREADY is withheld
        redir_valid = 1'b1; redir_pc = 32'h400; s_ar_en = 1'b0;
        step();
        redir_valid = 1'b0;
        chk("redir_out_ivalid", 32'(ivalid), 32'd0);
        chk("redir_out_araddr", araddr, 32'h400);
        redir_valid = 1'b1; redir_pc = 32'h500;
        step();
        redir_pc = 32'h600;
        step();
        redir_valid = 1'b0;
        chk("ar_hold_arvalid", 32'(arvalid), 32'd1);
        chk("ar_hold_araddr", araddr, 32'h400);
        s_ar_en = 1'b1; s_resp = 2'b10;
        step();
        s_resp = RESP_OKAY;
        step();
        chk("b2b_araddr", araddr, 32'h600);
        chk("discard_err_nofault", 32'(fault), 32'd0);
        wait_until(0, "b2b_fetch");
        chk("b2b_fetch_pc", ipc, 32'h600);
        chk("b2b_fetch_data", idata, 32'h0060_0013);

        // Error response is sticky until reset
        iready = 1'b1; s_resp = 2'b10;
        step();
        iready = 1'b0;
        wait_until(2, "rresp_fault");
        for (int k = 0; k < 5; k++) begin
            redir_valid = (k == 0); redir_pc = 32'h700;
            step();
            chk("fault_hold", {28'h0, arvalid, rready, ivalid, fault}, 32'h1);
        end
        redir_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("fault_rst_clear", 32'(fault), 32'd0);
        chk("fault_rst_ipc", ipc, 32'h100);
        s_resp = RESP_OKAY;
        rst = 1'b0;
        wait_until(0, "post_rst_fetch");
        chk("post_rst_pc", ipc, 32'h100);
        chk("post_rst_data", idata, 32'h0050_0093);

        // Misaligned redirect target faults without any address handshake
        ar0 = ar_count;
        redir_valid = 1'b1; redir_pc = 32'h102;
        step();
        redir_valid = 1'b0;
        chk("misalign_fault", 32'(fault), 32'd1);
        chk("misalign_arvalid", 32'(arvalid), 32'd0);
        step();
        step();
        step();
        chk("misalign_no_ar", ar_count, ar0);
        chk("misalign_ivalid", 32'(ivalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_axi.md
Name: ifetch_axi

Overview:
- AXI4-Lite read master that fetches 32-bit instructions from the instruction memory slave and hands them to decode over a valid/ready interface.
- Owns the PC and advances it by 4 per fetch.
- Accepts branch/jump redirects from execute.
- Sits directly upstream of the instruction memory's AR/R channels and directly upstream of decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- AXI_AWIDTH, 32, ARADDR width.
- AXI_DWIDTH, 32, RDATA width; must be 32.
- WORD_ADDR, 0, 0: ARADDR = PC[AXI_AWIDTH-1:0] (byte address); 1: ARADDR = PC[AXI_AWIDTH+1:2] (word index).

Ports:
- AXI_ACLK  in  1  system clock, all state on rising edge.
- AXI_ARESET  in  1  asynchronous, active-high reset.
- AXI_ARADDR  out  AXI_AWIDTH  fetch address.
- AXI_ARVALID  out  1  address valid.
- AXI_ARREADY  in  1  address accepted.
- AXI_RDATA  in  AXI_DWIDTH  instruction word.
- AXI_RRESP  in  2  response; 2'b00 = OKAY.
- AXI_RVALID  in  1  read data valid.
- AXI_RREADY  out  1  master ready for data.
- REDIR_VALID  in  1  one-cycle redirect strobe from execute.
- REDIR_PC  in  32  redirect target.
- INSTR_VALID  out  1  instruction available to decode.
- INSTR_READY  in  1  decode accepts.
- INSTR_DATA  out  32  fetched instruction.
- INSTR_PC  out  32  PC of INSTR_DATA.
- FETCH_FAULT  out  1  sticky error flag: RRESP != OKAY or misaligned PC.

Behaviour:
- Reset (async assert, sync release):
  - state = S_IDLE; PC = RESET_PC.
  - ARVALID = 0, RREADY = 0, INSTR_VALID = 0, FETCH_FAULT = 0.
  - INSTR_DATA = 32'h0000_0013 (NOP), INSTR_PC = RESET_PC, ARADDR derived from PC.
  - Reset mid-transaction abandons it; the slave's in-flight response is not consumed.
- All outputs are registered.
- States: S_IDLE, S_REQ, S_RESP, S_OUT, S_FAULT.
- S_IDLE: one cycle after reset release, then go to S_REQ.
- S_REQ:
  - ARVALID = 1 and RREADY = 1; ARADDR is held stable until ARREADY.
  - ARREADY and RVALID in the same cycle: capture data, go to S_OUT. The slave returns both together, so minimum fetch latency is 2 cycles from ARVALID rise to INSTR_VALID.
  - ARREADY without RVALID: drop ARVALID, keep RREADY, go to S_RESP.
- S_RESP: wait for RVALID with RREADY = 1, then capture data and go to S_OUT.
- Capture: INSTR_DATA <= RDATA, INSTR_PC <= PC, PC <= PC + 4 (32-bit wrap, no flag). RREADY deasserts.
- S_OUT:
  - INSTR_VALID = 1; DATA/PC stable until INSTR_READY.
  - On accept, drop INSTR_VALID and go to S_REQ next cycle. No prefetch; throughput is one instruction per 3 cycles.
- Redirect:
  - Target is stored in a pending register plus a flush flag.
  - In S_IDLE or S_OUT: PC <= REDIR_PC immediately; INSTR_VALID drops next cycle; go to S_REQ.
  - In S_REQ or S_RESP: the AXI transaction completes normally (ARVALID is never withdrawn before ARREADY). The response is discarded, INSTR_VALID is not raised, PC is not incremented, PC <= target, and the next state is S_REQ.
  - Redirect in the same cycle as the INSTR_READY handshake: the handshake stands; the next fetch is from REDIR_PC.
  - Back-to-back redirects: the last one wins.
- Fault:
  - RRESP != 2'b00, or PC[1:0] != 0 at S_REQ entry, sets FETCH_FAULT, enters S_FAULT, and no instruction is presented.
  - S_FAULT holds ARVALID = 0, RREADY = 0, INSTR_VALID = 0 until reset; redirects are ignored.
- A discarded response carrying an error RRESP is ignored (no fault).

Decomposition:
- Shared package ifetch_pkg holds:
  - state encoding localparams S_IDLE..S_FAULT;
  - NOP_INSTR = 32'h0000_0013;
  - RESP_OKAY = 2'b00.
- No sub-module: the FSM and the PC/redirect register fit in one module.

Test Plan:
- Reset with RESET_PC = 32'h100, zero-wait slave returning 32'h00500093 -> ARADDR = 32'h100; INSTR_VALID 2 cycles after ARVALID rise; INSTR_PC = 32'h100; next ARADDR = 32'h104.
- INSTR_READY held 0 for 5 cycles -> INSTR_DATA/INSTR_PC stable, no new ARVALID; single fetch issued after release.
- REDIR_VALID with REDIR_PC = 32'h200 while in S_RESP, slave delaying RVALID by 3 cycles -> response discarded, INSTR_VALID stays 0, next ARADDR = 32'h200.
- REDIR_VALID in the same cycle as INSTR_READY in S_OUT -> instruction consumed once; next ARADDR = REDIR_PC.
- Slave returns RRESP = 2'b10 -> FETCH_FAULT = 1; ARVALID, RREADY and INSTR_VALID = 0 permanently; cleared only by AXI_ARESET.
- Redirect to 32'h0000_0102 -> FETCH_FAULT = 1 with no AR handshake; WORD_ADDR = 1 build, PC = 32'h10 -> ARADDR = 4.
